// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Single-outstanding load/store engine between a pipeline and a word-wide
//   data memory with combinational read. Byte and halfword stores are done
//   as read-modify-write; loads are lane-selected and sign/zero-extended.
//
// Ports
//   CLK, RST                 clock, asynchronous active-high reset
//   req_valid / req_ready    request handshake (ready only when idle)
//   req_we, req_funct3       store flag, access size/sign (RISC-V encoding)
//   req_addr, req_wdata      byte address, right-aligned store data
//   resp_valid / resp_ready  response handshake
//   resp_rdata, resp_err     extended load data (0 for stores/errors), error
//   mem_A, mem_WE, mem_WD    data-memory word address, write enable, data
//   mem_RD                   data-memory combinational read data
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int A_WIDTH = 20,
    parameter int D_WIDTH = 32   // only 32 is supported
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [D_WIDTH-1:0] req_wdata,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [D_WIDTH-1:0] resp_rdata,
    output logic               resp_err,
    output logic [A_WIDTH-1:0] mem_A,
    output logic               mem_WE,
    output logic [D_WIDTH-1:0] mem_WD,
    input  logic [D_WIDTH-1:0] mem_RD
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_READ,
        WRITE,
        RESP
    } state_t;

    state_t               state_q,  state_d;
    logic [A_WIDTH+1:0]   addr_q,   addr_d;
    logic [2:0]           funct3_q, funct3_d;
    logic                 we_q,     we_d;
    logic [D_WIDTH-1:0]   wdata_q,  wdata_d;
    logic [D_WIDTH-1:0]   word_q,   word_d;    // merged RMW word
    logic [D_WIDTH-1:0]   rdata_q,  rdata_d;   // extended load result
    logic                 err_q,    err_d;

    logic                 req_err;
    logic [4:0]           lane_shift;
    logic [D_WIDTH-1:0]   lane_data;
    logic [D_WIDTH-1:0]   lane_mask;
    logic [D_WIDTH-1:0]   load_data;
    logic [D_WIDTH-1:0]   merged_word;

    // Address bits above the memory window are dropped on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:A_WIDTH+2];

    // Legality of the incoming request.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        req_err = 1'b0;
        case (req_funct3)
            3'b000:  req_err = 1'b0;
            3'b001:  req_err = req_addr[0];
            3'b010:  req_err = (req_addr[1:0] != 2'b00);
            3'b100:  req_err = req_we;
            3'b101:  req_err = req_we | req_addr[0];
            default: req_err = 1'b1;
        endcase
    end

    // Lane handling on the registered address (little-endian).
    always_comb begin
        lane_shift  = {addr_q[1:0], 3'b000};
        lane_data   = mem_RD >> lane_shift;
        lane_mask   = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << lane_shift;
        merged_word = (mem_RD & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);

        // funct3[2] selects zero extension for BU/HU.
        case (funct3_q[1:0])
            2'b00:   load_data = {{24{lane_data[7]  & ~funct3_q[2]}}, lane_data[7:0]};
            2'b01:   load_data = {{16{lane_data[15] & ~funct3_q[2]}}, lane_data[15:0]};
            default: load_data = mem_RD;
        endcase
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr[A_WIDTH+1:0];
                    funct3_d = req_funct3;
                    we_d     = req_we;
                    wdata_d  = req_wdata;
                    err_d    = req_err;
                    if (req_err)          state_d = RESP;
                    else if (!req_we)     state_d = LOAD;
                    else if (req_funct3[1]) state_d = WRITE;     // SW
                    else                  state_d = RMW_READ;  // SB/SH
                end
            end
            LOAD: begin
                rdata_d = load_data;
                state_d = RESP;
            end
            RMW_READ: begin
                word_d  = merged_word;
                state_d = WRITE;
            end
            WRITE: begin
                state_d = RESP;
            end
            RESP: begin
                // Returning to IDLE (not accepting here) guarantees one idle cycle.
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (RST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = err_q;
    // rdata_q keeps the last load value; stores and errors report zero.
    assign resp_rdata = (we_q || err_q) ? '0 : rdata_q;
    assign mem_A      = addr_q[A_WIDTH+1:2];
    assign mem_WE     = (state_q == WRITE);
    assign mem_WD     = (state_q == WRITE) ? (funct3_q[1] ? wdata_q : word_q) : '0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [19:0] mem_A;
    logic        mem_WE;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.A_WIDTH(20), .D_WIDTH(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_A      (mem_A),
        .mem_WE     (mem_WE),
        .mem_WD     (mem_WD),
        .mem_RD     (mem_RD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Data memory: 256 words, combinational read, preload port used under reset.
    logic [31:0] dmem [0:255];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;
    int          we_seen_in_reset = 0;

    assign mem_RD = dmem[mem_A[7:0]];

    always @(posedge CLK) begin
        if (pl_en)       dmem[pl_idx]     <= pl_data;
        else if (mem_WE) dmem[mem_A[7:0]] <= mem_WD;
        if (RST && mem_WE) we_seen_in_reset <= we_seen_in_reset + 1;
    end

    // Reference model: a flat byte array, accessed by byte address.
    logic [7:0] ref_b [0:1023];

    function automatic logic [31:0] ref_word(input int w);
        return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit ref_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
        case (f3)
            3'd0:    return 1'b0;
            3'd1:    return addr[0];
            3'd2:    return addr[1:0] != 2'b00;
            3'd4:    return we;
            3'd5:    return we || addr[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
        logic [31:0] v;
        int n;
        n = size_of(f3);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v + (32'(ref_b[a+i]) << (8*i));
        if (!f3[2] && n < 4 && v >= (32'd1 << (8*n-1))) v = v - (32'd1 << (8*n));
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction: drive, wait for response (bounded), check, consume.
    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int stall, input string tag);
        bit          e_err;
        int          e_lat;
        int          a;
        logic [31:0] e_rdata;
        logic [31:0] e_wd;
        int          lat;
        int          we_cnt;
        logic [31:0] wa;
        logic [31:0] wd;

        a       = int'(addr[9:0]);
        e_err   = ref_err(we, f3, addr);
        e_lat   = e_err ? 1 : (!we ? 2 : (f3 == 3'd2 ? 2 : 3));
        e_rdata = (e_err || we) ? 32'd0 : ref_load(f3, a);

        @(negedge CLK);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge CLK);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;

        lat = 0;
        we_cnt = 0;
        wa = 32'd0;
        wd = 32'd0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            if (mem_WE) begin
                we_cnt++;
                wa = 32'(mem_A);
                wd = mem_WD;
            end
            if (resp_valid) begin
                lat = c;
                break;
            end
        end

        if (!e_err && we)
            for (int i = 0; i < size_of(f3); i++) ref_b[a+i] = wdata[8*i +: 8];
        e_wd = ref_word(a / 4);

        check({tag, "_lat"},   32'(lat),      32'(e_lat));
        check({tag, "_err"},   32'(resp_err), 32'(e_err));
        check({tag, "_rdata"}, resp_rdata,    e_rdata);
        check({tag, "_wecnt"}, 32'(we_cnt),   (!e_err && we) ? 32'd1 : 32'd0);
        if (!e_err && we) begin
            check({tag, "_memA"},  wa, 32'(addr[21:2]));
            check({tag, "_memWD"}, wd, e_wd);
        end
        if (lat == 0) return;

        // Back-pressure: response must hold and new requests must be ignored.
        for (int s = 0; s < stall; s++) begin
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_funct3 = 3'd2;
            req_addr   = 32'd0;
            req_wdata  = $urandom;
            @(negedge CLK);
            check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
            check({tag, "_hold_rdata"}, resp_rdata,      e_rdata);
            check({tag, "_hold_err"},   32'(resp_err),   32'(e_err));
            check({tag, "_hold_ready"}, 32'(req_ready),  32'd0);
            check({tag, "_hold_we"},    32'(mem_WE),     32'd0);
        end

        resp_ready = 1'b1;
        @(posedge CLK);
        #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
    endtask

    initial begin
        logic [31:0] addr;
        logic [2:0]  f3;
        bit          we;
        int          bad;

        RST        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;
        pl_en      = 1'b0;
        pl_idx     = 8'd0;
        pl_data    = 32'd0;

        #1 RST = 1'b1;
        #1;
        check("rst_req_ready",  32'(req_ready),  32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err",   32'(resp_err),   32'd0);
        check("rst_resp_rdata", resp_rdata,      32'd0);
        check("rst_mem_we",     32'(mem_WE),     32'd0);
        check("rst_mem_wd",     mem_WD,          32'd0);
        check("rst_mem_a",      32'(mem_A),      32'd0);

        // Preload memory and reference while reset is held.
        for (int w = 0; w < 256; w++) begin
            logic [31:0] v;
            v = (w == 4) ? 32'h80FF_7F01 : (w == 2) ? 32'h1122_3344 : $urandom;
            for (int b = 0; b < 4; b++) ref_b[4*w+b] = v[8*b +: 8];
            @(negedge CLK);
            pl_en   = 1'b1;
            pl_idx  = 8'(w);
            pl_data = v;
        end
        @(negedge CLK);
        pl_en = 1'b0;
        check("rst_hold_no_we", 32'(we_seen_in_reset), 32'd0);
        check("rst_hold_ready", 32'(req_ready),        32'd1);

        @(posedge CLK);
        #1 RST = 1'b0;

        // Directed cases.
        do_req(1'b0, 3'b000, 32'h13, 32'd0, 0, "lb_13");
        do_req(1'b0, 3'b100, 32'h13, 32'd0, 0, "lbu_13");
        do_req(1'b0, 3'b001, 32'h12, 32'd0, 0, "lh_12");
        do_req(1'b1, 3'b000, 32'h09, 32'hAB, 0, "sb_09");
        check("sb_09_word", dmem[2], 32'h1122_AB44);
        do_req(1'b1, 3'b010, 32'h04, 32'hDEAD_BEEF, 0, "sw_04");
        do_req(1'b0, 3'b010, 32'h04, 32'd0, 0, "lw_04");
        do_req(1'b0, 3'b010, 32'h06, 32'd0, 0, "lw_06_err");
        do_req(1'b1, 3'b001, 32'h03, 32'h1234, 0, "sh_03_err");
        do_req(1'b0, 3'b011, 32'h00, 32'd0, 0, "f3_011_err");
        do_req(1'b1, 3'b100, 32'h20, 32'h55, 0, "sbu_err");
        do_req(1'b1, 3'b001, 32'hFFC0_0016, 32'hCAFE, 0, "sh_hi_bits");
        do_req(1'b0, 3'b010, 32'h08, 32'd0, 5, "lw_stall");

        // Reset during RMW_READ of an SB must drop the write.
        @(negedge CLK);
        check("rmw_rst_ready", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h21;
        req_wdata  = 32'h5A;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rmw_rst_we",    32'(mem_WE),     32'd0);
        check("rmw_rst_rdy",   32'(req_ready),  32'd1);
        check("rmw_rst_valid", 32'(resp_valid), 32'd0);
        check("rmw_rst_memA",  32'(mem_A),      32'd0);
        @(posedge CLK);
        #1;
        check("rmw_rst_we2", 32'(mem_WE), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("rmw_rst_noresp", 32'(resp_valid), 32'd0);
        check("rmw_rst_word",   dmem[8],         ref_word(8));

        // Randomized traffic against the byte-array model.
        for (int n = 0; n < 300; n++) begin
            we   = 1'($urandom);
            f3   = 3'($urandom_range(0, 7));
            addr = (32'($urandom_range(0, 1023)) << 22) | 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0)
                addr[1:0] = addr[1:0] & ~((f3[1:0] == 2'd2) ? 2'b11 : (f3[1:0] == 2'd1) ? 2'b01 : 2'b00);
            do_req(we, f3, addr, $urandom, int'($urandom_range(0, 2)), "rnd");
        end

        bad = 0;
        for (int w = 0; w < 256; w++) if (dmem[w] !== ref_word(w)) bad++;
        check("mem_final", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter A_WIDTH, default 20, giving the data-memory word-address width.
REQ-002 The block SHALL have parameter D_WIDTH, default 32, giving the data width; only 32 is supported.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the pipeline presents a memory request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 means store, 0 means load.
REQ-008 The block SHALL have port req_funct3, input, 3 bits: access size/sign. 000 B, 001 H, 010 W, 100 BU, 101 HU; BU/HU are legal for loads only.
REQ-009 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 The block SHALL have port resp_valid, output, 1 bit: a response is available.
REQ-012 The block SHALL have port resp_ready, input, 1 bit: the pipeline consumes the response.
REQ-013 The block SHALL have port resp_rdata, output, 32 bits: load result after extension; 0 for stores and errors.
REQ-014 The block SHALL have port resp_err, output, 1 bit: misaligned access or illegal funct3.
REQ-015 The block SHALL have port mem_A, output, A_WIDTH bits: word address to data memory.
REQ-016 The block SHALL have port mem_WE, output, 1 bit: data-memory write enable.
REQ-017 The block SHALL have port mem_WD, output, 32 bits: data-memory write data.
REQ-018 The block SHALL have port mem_RD, input, 32 bits: data-memory combinational read data.

Function
REQ-019 The block SHALL use FSM states IDLE, LOAD, RMW_READ, WRITE and RESP.
REQ-020 req_ready SHALL be 1 only in IDLE.
REQ-021 A request SHALL be accepted on the rising edge where req_valid=1 and req_ready=1; on acceptance the block registers addr, funct3, we and wdata.
REQ-022 The block SHALL set mem_A = registered addr[A_WIDTH+1:2]; address bits above A_WIDTH+1 are ignored.
REQ-023 An access SHALL be an error when H/HU has addr[0]=1, when W has addr[1:0]!=0, when funct3 is 011, 110 or 111, or when a store uses 100 or 101.
REQ-024 Transitions on acceptance from IDLE SHALL be: error -> RESP with err; load -> LOAD; SW -> WRITE; SB or SH -> RMW_READ.
REQ-025 In LOAD, the block SHALL capture mem_RD at the edge, then go to RESP.
REQ-026 In RMW_READ, the block SHALL capture mem_RD at the edge, merge the store byte or halfword into the lane selected by addr[1:0] (little-endian), then go to WRITE.
REQ-027 In WRITE, mem_WE SHALL be 1 for exactly one cycle, with mem_WD = the merged word (SB/SH) or req_wdata (SW); then go to RESP.
REQ-028 mem_WE SHALL be 0 in every state other than WRITE; error requests SHALL never assert mem_WE.
REQ-029 Load extension: B/H sign-extend bit 7/15 of the selected lane; BU/HU zero-extend; W passes the word unchanged.
REQ-030 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL be held stable until the edge where resp_ready=1, then go to IDLE.
REQ-031 A new request SHALL NOT be accepted in the same cycle that a response is consumed, so there is always one IDLE cycle between requests.
REQ-032 Latency from the accept edge to resp_valid SHALL be: error 1 cycle; LW/LB/LH/LBU/LHU 2 cycles; SW 2 cycles; SB/SH 3 cycles.
REQ-033 resp_rdata SHALL be 0 for all stores and all errors.
REQ-034 Inputs presented in non-IDLE states SHALL be ignored.

Reset
REQ-035 While RST=1, the block SHALL immediately force state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_WE=0, mem_WD=0, mem_A=0, and clear all registered request fields.
REQ-036 A reset asserted mid-operation SHALL abort the access; a pending WRITE SHALL NOT reach memory and no response SHALL be produced.
REQ-037 After RST deasserts, the first request SHALL be acceptable on the first rising edge.

Verification
REQ-038 Memory word 4 = 0x80FF_7F01; LB at addr 0x13 -> resp_rdata=0xFFFFFF80, 2 cycles after accept; LBU at 0x13 -> 0x00000080; LH at 0x12 -> 0xFFFF80FF.
REQ-039 Word 2 = 0x11223344; SB wdata=0xAB at addr 0x09 -> one mem_WE pulse with mem_A=2 and mem_WD=0x1122AB44; resp_valid 3 cycles after accept.
REQ-040 SW 0xDEADBEEF at 0x04 -> a single-cycle mem_WE with mem_WD=0xDEADBEEF, then LW at 0x04 -> 0xDEADBEEF.
REQ-041 LW at 0x06, SH at 0x03, or funct3=011 -> resp_err=1 after 1 cycle, resp_rdata=0, mem_WE never asserted.
REQ-042 resp_ready held 0 for 5 cycles -> resp_valid, resp_rdata and resp_err stable and req_ready=0 throughout; the next request is accepted only after the consume edge plus one IDLE cycle.
REQ-043 RST pulsed during RMW_READ of an SB -> mem_WE stays 0, the memory word is unchanged, and the block is in IDLE with req_ready=1.
